// File: rtl/xbar_resp_core.sv
// Response crossbar: four bank skid FIFOs feed three channel output slots.
// Each bank head is steered by its one-hot channel id; a round-robin arbiter
// per channel resolves banks that collide on the same channel.
module xbar_resp_core #(
   parameter int DATA_W    = 32,
   parameter int WBUF_W    = 4,
   parameter int BUF_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              u_bank_0_resp_valid,
   output logic              u_bank_0_resp_ready,
   input  logic [2:0]        u_bank_0_resp_ch_1hot_id,
   input  logic              u_bank_0_resp_is_write,
   input  logic [DATA_W-1:0] u_bank_0_resp_rdata,
   input  logic [WBUF_W-1:0] u_bank_0_resp_wbuf_id,
   input  logic              u_bank_1_resp_valid,
   output logic              u_bank_1_resp_ready,
   input  logic [2:0]        u_bank_1_resp_ch_1hot_id,
   input  logic              u_bank_1_resp_is_write,
   input  logic [DATA_W-1:0] u_bank_1_resp_rdata,
   input  logic [WBUF_W-1:0] u_bank_1_resp_wbuf_id,
   input  logic              u_bank_2_resp_valid,
   output logic              u_bank_2_resp_ready,
   input  logic [2:0]        u_bank_2_resp_ch_1hot_id,
   input  logic              u_bank_2_resp_is_write,
   input  logic [DATA_W-1:0] u_bank_2_resp_rdata,
   input  logic [WBUF_W-1:0] u_bank_2_resp_wbuf_id,
   input  logic              u_bank_3_resp_valid,
   output logic              u_bank_3_resp_ready,
   input  logic [2:0]        u_bank_3_resp_ch_1hot_id,
   input  logic              u_bank_3_resp_is_write,
   input  logic [DATA_W-1:0] u_bank_3_resp_rdata,
   input  logic [WBUF_W-1:0] u_bank_3_resp_wbuf_id,
   output logic              d_channel_0_resp_valid,
   input  logic              d_channel_0_resp_ready,
   output logic              d_channel_0_resp_is_write,
   output logic [DATA_W-1:0] d_channel_0_resp_rdata,
   output logic [WBUF_W-1:0] d_channel_0_resp_wbuf_id,
   output logic [1:0]        d_channel_0_resp_bank_id,
   output logic              d_channel_1_resp_valid,
   input  logic              d_channel_1_resp_ready,
   output logic              d_channel_1_resp_is_write,
   output logic [DATA_W-1:0] d_channel_1_resp_rdata,
   output logic [WBUF_W-1:0] d_channel_1_resp_wbuf_id,
   output logic [1:0]        d_channel_1_resp_bank_id,
   output logic              d_channel_2_resp_valid,
   input  logic              d_channel_2_resp_ready,
   output logic              d_channel_2_resp_is_write,
   output logic [DATA_W-1:0] d_channel_2_resp_rdata,
   output logic [WBUF_W-1:0] d_channel_2_resp_wbuf_id,
   output logic [1:0]        d_channel_2_resp_bank_id,
   output logic              err_illegal_id
);
   localparam int NB    = 4;
   localparam int NC    = 3;
   localparam int PTR_W = $clog2(BUF_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // True only for ids that name exactly one channel.
   function automatic logic is_one_hot(input logic [2:0] id);
      logic r;
      case (id)
         3'b001, 3'b010, 3'b100: r = 1'b1;
         default:                r = 1'b0;
      endcase
      return r;
   endfunction

   logic [NB-1:0]     in_valid, in_is_write, push, pop, full, empty, head_legal;
   logic [2:0]        in_id    [NB];
   logic [DATA_W-1:0] in_rdata [NB];
   logic [WBUF_W-1:0] in_wbuf  [NB];

   logic [2:0]        mem_id    [NB][BUF_DEPTH];
   logic              mem_wr    [NB][BUF_DEPTH];
   logic [DATA_W-1:0] mem_rdata [NB][BUF_DEPTH];
   logic [WBUF_W-1:0] mem_wbuf  [NB][BUF_DEPTH];
   logic [PTR_W-1:0]  wr_ptr [NB];
   logic [PTR_W-1:0]  rd_ptr [NB];
   logic [CNT_W-1:0]  count  [NB];

   logic [NB-1:0]     req [NC];
   logic [NC-1:0]     slot_free, gnt_valid;
   logic [1:0]        gnt_idx [NC];
   logic [1:0]        rr_ptr  [NC];

   logic [NC-1:0]     out_valid, out_is_write;
   logic [DATA_W-1:0] out_rdata [NC];
   logic [WBUF_W-1:0] out_wbuf  [NC];
   logic [1:0]        out_bank  [NC];

   assign in_valid    = {u_bank_3_resp_valid, u_bank_2_resp_valid, u_bank_1_resp_valid, u_bank_0_resp_valid};
   assign in_is_write = {u_bank_3_resp_is_write, u_bank_2_resp_is_write, u_bank_1_resp_is_write, u_bank_0_resp_is_write};
   assign in_id[0] = u_bank_0_resp_ch_1hot_id;  assign in_rdata[0] = u_bank_0_resp_rdata;  assign in_wbuf[0] = u_bank_0_resp_wbuf_id;
   assign in_id[1] = u_bank_1_resp_ch_1hot_id;  assign in_rdata[1] = u_bank_1_resp_rdata;  assign in_wbuf[1] = u_bank_1_resp_wbuf_id;
   assign in_id[2] = u_bank_2_resp_ch_1hot_id;  assign in_rdata[2] = u_bank_2_resp_rdata;  assign in_wbuf[2] = u_bank_2_resp_wbuf_id;
   assign in_id[3] = u_bank_3_resp_ch_1hot_id;  assign in_rdata[3] = u_bank_3_resp_rdata;  assign in_wbuf[3] = u_bank_3_resp_wbuf_id;

   // FIFO status flags, push qualification and head legality per bank.
   always_comb begin
      for (int b = 0; b < NB; b++) begin
         full[b]       = (count[b] == CNT_W'(BUF_DEPTH));
         empty[b]      = (count[b] == {CNT_W{1'b0}});
         push[b]       = in_valid[b] & ~full[b];
         head_legal[b] = is_one_hot(mem_id[b][rd_ptr[b]]);
      end
   end

   assign u_bank_0_resp_ready = ~full[0];
   assign u_bank_1_resp_ready = ~full[1];
   assign u_bank_2_resp_ready = ~full[2];
   assign u_bank_3_resp_ready = ~full[3];

   assign slot_free = ~out_valid | {d_channel_2_resp_ready, d_channel_1_resp_ready, d_channel_0_resp_ready};

   // Per-channel request vectors and round-robin grant starting at rr_ptr.
   always_comb begin
      logic [1:0] idx;
      idx = 2'd0;
      for (int c = 0; c < NC; c++) begin
         gnt_valid[c] = 1'b0;
         gnt_idx[c]   = 2'd0;
         for (int b = 0; b < NB; b++) begin
            req[c][b] = ~empty[b] & head_legal[b] & mem_id[b][rd_ptr[b]][c];
         end
         for (int i = 0; i < NB; i++) begin
            idx = rr_ptr[c] + 2'(i);
            if (slot_free[c] && !gnt_valid[c] && req[c][idx]) begin
               gnt_valid[c] = 1'b1;
               gnt_idx[c]   = idx;
            end else begin
               gnt_valid[c] = gnt_valid[c];
            end
         end
      end
   end

   // A bank pops when granted by any channel or when its head is illegal.
   always_comb begin
      for (int b = 0; b < NB; b++) begin
         pop[b] = ~empty[b] & ~head_legal[b];
         for (int c = 0; c < NC; c++) begin
            pop[b] = pop[b] | (gnt_valid[c] & (gnt_idx[c] == 2'(b)));
         end
      end
   end

   // Bank FIFO storage, pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < NB; b++) begin
            wr_ptr[b] <= {PTR_W{1'b0}};
            rd_ptr[b] <= {PTR_W{1'b0}};
            count[b]  <= {CNT_W{1'b0}};
            for (int e = 0; e < BUF_DEPTH; e++) begin
               mem_id[b][e]    <= 3'b000;
               mem_wr[b][e]    <= 1'b0;
               mem_rdata[b][e] <= {DATA_W{1'b0}};
               mem_wbuf[b][e]  <= {WBUF_W{1'b0}};
            end
         end
      end else begin
         for (int b = 0; b < NB; b++) begin
            if (push[b]) begin
               mem_id[b][wr_ptr[b]]    <= in_id[b];
               mem_wr[b][wr_ptr[b]]    <= in_is_write[b];
               mem_rdata[b][wr_ptr[b]] <= in_rdata[b];
               mem_wbuf[b][wr_ptr[b]]  <= in_wbuf[b];
               wr_ptr[b]               <= wr_ptr[b] + PTR_W'(1'b1);
            end
            if (pop[b]) begin
               rd_ptr[b] <= rd_ptr[b] + PTR_W'(1'b1);
            end
            count[b] <= count[b] + CNT_W'(push[b]) - CNT_W'(pop[b]);
         end
      end
   end

   // Channel output slots and round-robin pointers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid    <= 3'b000;
         out_is_write <= 3'b000;
         for (int c = 0; c < NC; c++) begin
            out_rdata[c] <= {DATA_W{1'b0}};
            out_wbuf[c]  <= {WBUF_W{1'b0}};
            out_bank[c]  <= 2'd0;
            rr_ptr[c]    <= 2'd0;
         end
      end else begin
         for (int c = 0; c < NC; c++) begin
            if (slot_free[c]) begin
               if (gnt_valid[c]) begin
                  out_valid[c]    <= 1'b1;
                  out_is_write[c] <= mem_wr[gnt_idx[c]][rd_ptr[gnt_idx[c]]];
                  out_rdata[c]    <= mem_rdata[gnt_idx[c]][rd_ptr[gnt_idx[c]]];
                  out_wbuf[c]     <= mem_wbuf[gnt_idx[c]][rd_ptr[gnt_idx[c]]];
                  out_bank[c]     <= gnt_idx[c];
                  rr_ptr[c]       <= gnt_idx[c] + 2'd1;
               end else begin
                  out_valid[c] <= 1'b0;
               end
            end
         end
      end
   end

   // Sticky illegal-id flag, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_illegal_id <= 1'b0;
      end else if (|(~empty & ~head_legal)) begin
         err_illegal_id <= 1'b1;
      end
   end

   assign d_channel_0_resp_valid    = out_valid[0];
   assign d_channel_0_resp_is_write = out_is_write[0];
   assign d_channel_0_resp_rdata    = out_rdata[0];
   assign d_channel_0_resp_wbuf_id  = out_wbuf[0];
   assign d_channel_0_resp_bank_id  = out_bank[0];
   assign d_channel_1_resp_valid    = out_valid[1];
   assign d_channel_1_resp_is_write = out_is_write[1];
   assign d_channel_1_resp_rdata    = out_rdata[1];
   assign d_channel_1_resp_wbuf_id  = out_wbuf[1];
   assign d_channel_1_resp_bank_id  = out_bank[1];
   assign d_channel_2_resp_valid    = out_valid[2];
   assign d_channel_2_resp_is_write = out_is_write[2];
   assign d_channel_2_resp_rdata    = out_rdata[2];
   assign d_channel_2_resp_wbuf_id  = out_wbuf[2];
   assign d_channel_2_resp_bank_id  = out_bank[2];
endmodule

// File: tb/tb_xbar_resp_core.sv
// Directed bench for xbar_resp_core: reset, steering, contention, parallel
// delivery, back-pressure, illegal ids and mid-operation reset.
module tb_xbar_resp_core;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [3:0]       b_valid = 4'b0, b_wr = 4'b0, b_ready;
   logic [3:0][2:0]  b_id = '0;
   logic [3:0][31:0] b_data = '0;
   logic [3:0][3:0]  b_wbuf = '0;
   logic [2:0]       c_valid, c_wr, c_ready = 3'b111;
   logic [2:0][31:0] c_rdata;
   logic [2:0][3:0]  c_wbuf;
   logic [2:0][1:0]  c_bank;
   logic             err;
   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   xbar_resp_core dut (
      .clk(clk), .rst_n(rst_n),
      .u_bank_0_resp_valid(b_valid[0]), .u_bank_0_resp_ready(b_ready[0]), .u_bank_0_resp_ch_1hot_id(b_id[0]),
      .u_bank_0_resp_is_write(b_wr[0]), .u_bank_0_resp_rdata(b_data[0]), .u_bank_0_resp_wbuf_id(b_wbuf[0]),
      .u_bank_1_resp_valid(b_valid[1]), .u_bank_1_resp_ready(b_ready[1]), .u_bank_1_resp_ch_1hot_id(b_id[1]),
      .u_bank_1_resp_is_write(b_wr[1]), .u_bank_1_resp_rdata(b_data[1]), .u_bank_1_resp_wbuf_id(b_wbuf[1]),
      .u_bank_2_resp_valid(b_valid[2]), .u_bank_2_resp_ready(b_ready[2]), .u_bank_2_resp_ch_1hot_id(b_id[2]),
      .u_bank_2_resp_is_write(b_wr[2]), .u_bank_2_resp_rdata(b_data[2]), .u_bank_2_resp_wbuf_id(b_wbuf[2]),
      .u_bank_3_resp_valid(b_valid[3]), .u_bank_3_resp_ready(b_ready[3]), .u_bank_3_resp_ch_1hot_id(b_id[3]),
      .u_bank_3_resp_is_write(b_wr[3]), .u_bank_3_resp_rdata(b_data[3]), .u_bank_3_resp_wbuf_id(b_wbuf[3]),
      .d_channel_0_resp_valid(c_valid[0]), .d_channel_0_resp_ready(c_ready[0]), .d_channel_0_resp_is_write(c_wr[0]),
      .d_channel_0_resp_rdata(c_rdata[0]), .d_channel_0_resp_wbuf_id(c_wbuf[0]), .d_channel_0_resp_bank_id(c_bank[0]),
      .d_channel_1_resp_valid(c_valid[1]), .d_channel_1_resp_ready(c_ready[1]), .d_channel_1_resp_is_write(c_wr[1]),
      .d_channel_1_resp_rdata(c_rdata[1]), .d_channel_1_resp_wbuf_id(c_wbuf[1]), .d_channel_1_resp_bank_id(c_bank[1]),
      .d_channel_2_resp_valid(c_valid[2]), .d_channel_2_resp_ready(c_ready[2]), .d_channel_2_resp_is_write(c_wr[2]),
      .d_channel_2_resp_rdata(c_rdata[2]), .d_channel_2_resp_wbuf_id(c_wbuf[2]), .d_channel_2_resp_bank_id(c_bank[2]),
      .err_illegal_id(err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      tests++; if (c_valid !== 3'b000) begin fails++; $display("FAIL reset_valid: got %b expected 000", c_valid); end
      tests++; if (b_ready !== 4'hF) begin fails++; $display("FAIL reset_ready: got %b expected 1111", b_ready); end
      tests++; if (c_rdata !== '0 || c_wbuf !== '0 || c_bank !== '0 || c_wr !== 3'b000) begin
         fails++; $display("FAIL reset_fields: rdata %h wbuf %h bank %h expected all 0", c_rdata, c_wbuf, c_bank); end
      tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", err); end
   endtask

   task automatic test_single_read();
      b_valid[2] = 1'b1; b_id[2] = 3'b010; b_data[2] = 32'hDEADBEEF; b_wr[2] = 1'b0;
      step();
      b_valid[2] = 1'b0;
      tests++; if (c_valid !== 3'b000) begin fails++; $display("FAIL single_cycle1: got %b expected 000", c_valid); end
      step();
      tests++; if (c_valid !== 3'b010) begin fails++; $display("FAIL single_valid: got %b expected 010", c_valid); end
      tests++; if (c_rdata[1] !== 32'hDEADBEEF) begin fails++; $display("FAIL single_rdata: got %h expected deadbeef", c_rdata[1]); end
      tests++; if (c_bank[1] !== 2'd2 || c_wr[1] !== 1'b0) begin
         fails++; $display("FAIL single_bank: got bank %0d wr %b expected 2/0", c_bank[1], c_wr[1]); end
      step();
      tests++; if (c_valid !== 3'b000) begin fails++; $display("FAIL single_drain: got %b expected 000", c_valid); end
   endtask

   task automatic test_contention();
      for (int b = 0; b < 4; b++) begin
         b_valid[b] = 1'b1; b_id[b] = 3'b001; b_wr[b] = 1'b0; b_data[b] = 32'h100 + b;
      end
      step();
      b_valid = 4'b0;
      step();
      for (int k = 0; k < 4; k++) begin
         tests++; if (c_valid !== 3'b001 || c_bank[0] !== 2'(k) || c_rdata[0] !== 32'h100 + k) begin
            fails++; $display("FAIL contention_%0d: got valid %b bank %0d rdata %h expected 001/%0d/%h",
                              k, c_valid, c_bank[0], c_rdata[0], k, 32'h100 + k); end
         step();
      end
      tests++; if (c_valid !== 3'b000) begin fails++; $display("FAIL contention_drain: got %b expected 000", c_valid); end
      // Pointer is back at 0, so bank 0 beats bank 3.
      b_valid = 4'b1001; b_data[0] = 32'h200; b_data[3] = 32'h203;
      step();
      b_valid = 4'b0;
      step();
      tests++; if (c_bank[0] !== 2'd0 || c_rdata[0] !== 32'h200) begin
         fails++; $display("FAIL rr_wrap_first: got bank %0d expected 0", c_bank[0]); end
      step();
      tests++; if (c_bank[0] !== 2'd3 || c_rdata[0] !== 32'h203 || c_valid[0] !== 1'b1) begin
         fails++; $display("FAIL rr_wrap_second: got bank %0d valid %b expected 3/1", c_bank[0], c_valid[0]); end
      step();
   endtask

   task automatic test_parallel();
      b_valid = 4'b1011;
      b_id[0] = 3'b100; b_data[0] = 32'hA0; b_wr[0] = 1'b0;
      b_id[1] = 3'b001; b_data[1] = 32'hB1; b_wr[1] = 1'b0;
      b_id[3] = 3'b010; b_data[3] = 32'h0;  b_wr[3] = 1'b1; b_wbuf[3] = 4'd5;
      step();
      b_valid = 4'b0;
      step();
      tests++; if (c_valid !== 3'b111) begin fails++; $display("FAIL parallel_valid: got %b expected 111", c_valid); end
      tests++; if (c_bank[2] !== 2'd0 || c_bank[0] !== 2'd1 || c_bank[1] !== 2'd3) begin
         fails++; $display("FAIL parallel_bank: got %0d %0d %0d expected 1 3 0", c_bank[0], c_bank[1], c_bank[2]); end
      tests++; if (c_wr[1] !== 1'b1 || c_wbuf[1] !== 4'd5) begin
         fails++; $display("FAIL parallel_wack: got wr %b wbuf %0d expected 1/5", c_wr[1], c_wbuf[1]); end
      tests++; if (c_rdata[2] !== 32'hA0 || c_rdata[0] !== 32'hB1) begin
         fails++; $display("FAIL parallel_rdata: got %h %h expected b1 a0", c_rdata[0], c_rdata[2]); end
      step();
      b_wr = 4'b0; b_wbuf = '0;
   endtask

   task automatic test_back_pressure();
      int idx = 0;
      logic acc;
      c_ready[1] = 1'b0;
      b_id[1] = 3'b010; b_wr[1] = 1'b0;
      for (int cyc = 0; cyc < 10; cyc++) begin
         if (cyc >= 2) begin
            tests++; if (c_valid[1] !== 1'b1 || c_rdata[1] !== 32'h300) begin
               fails++; $display("FAIL bp_hold_%0d: got valid %b rdata %h expected 1/300", cyc, c_valid[1], c_rdata[1]); end
         end
         b_valid[1] = (idx < 5); b_data[1] = 32'h300 + idx;
         acc = b_valid[1] & b_ready[1];
         step();
         if (acc) idx++;
      end
      tests++; if (idx != 3) begin fails++; $display("FAIL bp_accepted: got %0d expected 3", idx); end
      tests++; if (b_ready[1] !== 1'b0) begin fails++; $display("FAIL bp_ready_low: got %b expected 0", b_ready[1]); end
      c_ready[1] = 1'b1;
      for (int n = 0; n < 5; n++) begin
         tests++; if (c_valid[1] !== 1'b1 || c_rdata[1] !== 32'h300 + n) begin
            fails++; $display("FAIL bp_deliver_%0d: got valid %b rdata %h expected 1/%h", n, c_valid[1], c_rdata[1], 32'h300 + n); end
         b_valid[1] = (idx < 5); b_data[1] = 32'h300 + idx;
         acc = b_valid[1] & b_ready[1];
         step();
         if (acc) idx++;
      end
      b_valid[1] = 1'b0;
      tests++; if (c_valid[1] !== 1'b0 || idx != 5) begin
         fails++; $display("FAIL bp_end: got valid %b pushed %0d expected 0/5", c_valid[1], idx); end
   endtask

   task automatic test_illegal_id();
      b_valid[0] = 1'b1; b_id[0] = 3'b011; b_data[0] = 32'hBAD;
      step();
      tests++; if (err !== 1'b0) begin fails++; $display("FAIL illegal_early: got %b expected 0", err); end
      b_id[0] = 3'b100; b_data[0] = 32'hC2;
      step();
      b_valid[0] = 1'b0;
      tests++; if (err !== 1'b1 || c_valid !== 3'b000) begin
         fails++; $display("FAIL illegal_cycle2: got err %b valid %b expected 1/000", err, c_valid); end
      step();
      tests++; if (c_valid !== 3'b100 || c_rdata[2] !== 32'hC2 || c_bank[2] !== 2'd0) begin
         fails++; $display("FAIL illegal_next: got valid %b rdata %h bank %0d expected 100/c2/0", c_valid, c_rdata[2], c_bank[2]); end
      step();
      tests++; if (err !== 1'b1 || c_valid !== 3'b000) begin
         fails++; $display("FAIL illegal_sticky: got err %b valid %b expected 1/000", err, c_valid); end
   endtask

   task automatic test_reset_mid();
      c_ready = 3'b000;
      for (int b = 0; b < 4; b++) begin
         b_valid[b] = 1'b1; b_id[b] = 3'b001 << (b % 3); b_data[b] = 32'h400 + b;
      end
      repeat (3) step();
      tests++; if (c_valid !== 3'b111 || b_ready !== 4'b0000) begin
         fails++; $display("FAIL mid_loaded: got valid %b ready %b expected 111/0000", c_valid, b_ready); end
      #2 rst_n = 1'b0;
      b_valid = 4'b0;
      #1;
      tests++; if (c_valid !== 3'b000 || b_ready !== 4'hF || err !== 1'b0) begin
         fails++; $display("FAIL mid_async: got valid %b ready %b err %b expected 000/1111/0", c_valid, b_ready, err); end
      step(); step();
      rst_n = 1'b1;
      c_ready = 3'b111;
      for (int k = 0; k < 5; k++) begin
         step();
         tests++; if (c_valid !== 3'b000 || b_ready !== 4'hF) begin
            fails++; $display("FAIL mid_after_%0d: got valid %b ready %b expected 000/1111", k, c_valid, b_ready); end
      end
   endtask

   initial begin
      step(); step();
      test_reset();
      rst_n = 1'b1;
      step();
      test_single_read();
      test_contention();
      test_parallel();
      test_back_pressure();
      test_illegal_id();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
